// File: rtl/puzzle_move_engine_if.sv
// Controller handshake plus register-file bus of the 8-puzzle move engine.
interface puzzle_move_engine_if;
  logic       start;
  logic [1:0] dir;
  logic       busy;
  logic       done;
  logic [1:0] status;
  logic       solved;
  logic [3:0] blank_pos;
  logic [4:0] rf_raddr;
  logic [7:0] rf_rdata;
  logic [4:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       rf_we;

  modport master (
    input  start, dir, rf_rdata,
    output busy, done, status, solved, blank_pos,
           rf_raddr, rf_waddr, rf_wdata, rf_we
  );

  modport slave (
    output start, dir, rf_rdata,
    input  busy, done, status, solved, blank_pos,
           rf_raddr, rf_waddr, rf_wdata, rf_we
  );
endinterface

// File: rtl/puzzle_move_engine.sv
// 8-puzzle move engine: reads the packed board, moves the blank one step,
// writes the board back and bumps the saturating depth byte.
module puzzle_move_engine #(
  parameter logic [4:0]  BOARD_BASE = 5'd0,
  parameter logic [4:0]  DEPTH_ADDR = 5'd5,
  parameter logic [35:0] IDEAL      = 36'h123456780
) (
  input  logic clk,
  input  logic rst_n,
  puzzle_move_engine_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ, FIND, WRITE, DEPTH, DONE} state_t;

  state_t      state;
  logic [35:0] board;   // position p lives in bits [35-4p -: 4]
  logic [1:0]  dir_q;
  logic [2:0]  idx;
  logic [1:0]  st_q;
  logic [3:0]  bp_q;
  logic        sv_q;

  // Byte k of the packed file image; byte 4 carries pos 8 in its high nibble.
  function automatic logic [7:0] byte_of(input logic [35:0] b, input logic [2:0] i);
    if (i == 3'd4) return {b[3:0], 4'h0};
    return b[35-8*int'(i) -: 8];
  endfunction

  logic [3:0]  zcnt;
  int          bpos;
  int          tgt;
  logic        legal;
  logic [35:0] nboard;
  logic [1:0]  find_st;
  logic        fsolved;

  // Blank search, legality check and swap on the captured board.
  always_comb begin
    zcnt    = '0;
    bpos    = 0;
    tgt     = 0;
    legal   = 1'b0;
    nboard  = board;
    for (int p = 8; p >= 0; p--) begin
      if (board[35-4*p -: 4] == 4'h0) begin
        zcnt = zcnt + 4'd1;
        bpos = p;
      end
    end
    case (dir_q)
      2'b00: begin legal = (bpos / 3) > 0; tgt = bpos - 3; end
      2'b01: begin legal = (bpos / 3) < 2; tgt = bpos + 3; end
      2'b10: begin legal = (bpos % 3) > 0; tgt = bpos - 1; end
      default: begin legal = (bpos % 3) < 2; tgt = bpos + 1; end
    endcase
    if (zcnt != 4'd1)  find_st = 2'b10;
    else if (!legal)   find_st = 2'b01;
    else               find_st = 2'b00;
    if (find_st == 2'b00) begin
      nboard[35-4*bpos -: 4] = board[35-4*tgt -: 4];
      nboard[35-4*tgt -: 4]  = 4'h0;
    end
    fsolved = (find_st != 2'b10) && (nboard == IDEAL);
  end

  // Command sequencer; every bus output is registered.  The read port is
  // parked on the depth byte from FIND onward so its incremented value is
  // ready as registered write data for the DEPTH cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      board         <= '0;
      dir_q         <= '0;
      idx           <= '0;
      st_q          <= '0;
      bp_q          <= '0;
      sv_q          <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.status    <= '0;
      bus.solved    <= 1'b0;
      bus.blank_pos <= '0;
      bus.rf_raddr  <= '0;
      bus.rf_waddr  <= '0;
      bus.rf_wdata  <= '0;
      bus.rf_we     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done  <= 1'b0;
          bus.rf_we <= 1'b0;
          if (bus.start) begin
            dir_q        <= bus.dir;
            bus.busy     <= 1'b1;
            idx          <= '0;
            bus.rf_raddr <= BOARD_BASE;
            state        <= READ;
          end
        end
        READ: begin
          if (idx == 3'd4) begin
            board[3:0]   <= bus.rf_rdata[7:4];
            bus.rf_raddr <= DEPTH_ADDR;
            idx          <= '0;
            state        <= FIND;
          end else begin
            board[35-8*int'(idx) -: 8] <= bus.rf_rdata;
            bus.rf_raddr <= bus.rf_raddr + 5'd1;
            idx          <= idx + 3'd1;
          end
        end
        FIND: begin
          st_q <= find_st;
          bp_q <= 4'(bpos);
          sv_q <= fsolved;
          if (find_st == 2'b00) begin
            board        <= nboard;
            bus.rf_we    <= 1'b1;
            bus.rf_waddr <= BOARD_BASE;
            bus.rf_wdata <= byte_of(nboard, 3'd0);
            idx          <= '0;
            state        <= WRITE;
          end else begin
            bus.done      <= 1'b1;
            bus.status    <= find_st;
            bus.blank_pos <= 4'(bpos);
            bus.solved    <= fsolved;
            state         <= DONE;
          end
        end
        WRITE: begin
          if (idx == 3'd4) begin
            bus.rf_waddr <= DEPTH_ADDR;
            bus.rf_wdata <= (bus.rf_rdata == 8'hFF) ? 8'hFF : bus.rf_rdata + 8'd1;
            state        <= DEPTH;
          end else begin
            bus.rf_waddr <= bus.rf_waddr + 5'd1;
            bus.rf_wdata <= byte_of(board, idx + 3'd1);
            idx          <= idx + 3'd1;
          end
        end
        DEPTH: begin
          bus.rf_we     <= 1'b0;
          bus.done      <= 1'b1;
          bus.status    <= st_q;
          bus.blank_pos <= bp_q;
          bus.solved    <= sv_q;
          state         <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puzzle_move_engine.sv
// Directed bench for puzzle_move_engine with a behavioural register file.
module tb_puzzle_move_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  puzzle_move_engine_if bus();

  puzzle_move_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Register file: combinational read, synchronous write, bench preload.
  logic [7:0] mem [32];
  logic [7:0] pre [6];
  logic       ld = 1'b0;
  assign bus.rf_rdata = mem[bus.rf_raddr];
  always @(posedge clk) begin
    if (ld) begin
      for (int k = 0; k < 6; k++) mem[k] <= pre[k];
    end else if (bus.rf_we) begin
      mem[bus.rf_waddr] <= bus.rf_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  // Per-command observations, sampled on the falling edge of each cycle.
  int         done_cyc, ndone, nwr;
  logic [4:0] wa [16];
  logic [7:0] wd [16];
  int         wc [16];
  logic [1:0] st;
  logic       sv, busy1, busy_done, busy_after;
  logic [3:0] bp;

  task automatic load_rf(input logic [7:0] b0, b1, b2, b3, b4, dp);
    @(negedge clk);
    pre[0] = b0; pre[1] = b1; pre[2] = b2; pre[3] = b3; pre[4] = b4; pre[5] = dp;
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Issue one command; extra start pulses in cycles p1/p2; watch ncyc cycles.
  task automatic run_cmd(input logic [1:0] d, input int p1, input int p2, input int ncyc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dir   = d;
    @(posedge clk);
    done_cyc = 0; ndone = 0; nwr = 0;
    busy1 = 1'b0; busy_done = 1'b0; busy_after = 1'b1;
    st = 'x; sv = 'x; bp = 'x;
    for (int i = 0; i < 16; i++) begin wa[i] = 'x; wd[i] = 'x; wc[i] = -1; end
    @(negedge clk);
    for (int n = 1; n <= ncyc; n++) begin
      if (n > 1) @(negedge clk);
      bus.start = (n == p1) || (n == p2);
      if (n == 1) busy1 = bus.busy;
      if (done_cyc > 0 && n == done_cyc + 1) busy_after = bus.busy;
      if (bus.rf_we && nwr < 16) begin
        wa[nwr] = bus.rf_waddr; wd[nwr] = bus.rf_wdata; wc[nwr] = n; nwr++;
      end
      if (bus.done) begin
        ndone++; done_cyc = n;
        st = bus.status; sv = bus.solved; bp = bus.blank_pos; busy_done = bus.busy;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    int nw;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.dir = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.status, bus.solved, bus.blank_pos} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b status=%b solved=%b bp=%0d, want all 0",
               bus.busy, bus.done, bus.status, bus.solved, bus.blank_pos);
    end
    checks++;
    if ({bus.rf_we, bus.rf_raddr, bus.rf_waddr, bus.rf_wdata} !== 19'd0) begin
      errors++;
      $display("FAIL reset_bus: got we=%b raddr=%0d waddr=%0d wdata=%h, want 0",
               bus.rf_we, bus.rf_raddr, bus.rf_waddr, bus.rf_wdata);
    end
    rst_n = 1'b1;
    nw = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.rf_we || bus.busy) nw++;
    end
    checks++;
    if (nw !== 0) begin
      errors++;
      $display("FAIL reset_idle: got %0d active cycles, want 0", nw);
    end
  endtask

  task automatic test_legal();
    logic [7:0] ed [6];
    ed = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h01};
    load_rf(8'h12, 8'h34, 8'h50, 8'h78, 8'h60, 8'h00);
    run_cmd(2'b01, 0, 0, 16);
    checks++;
    if (nwr !== 6) begin
      errors++; $display("FAIL legal_nwr: got %0d, want 6", nwr);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wa[i] !== 5'(i) || wd[i] !== ed[i] || wc[i] !== 7 + i) begin
        errors++;
        $display("FAIL legal_write%0d: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d",
                 i, wa[i], wd[i], wc[i], i, ed[i], 7 + i);
      end
    end
    checks++;
    if (done_cyc !== 13 || ndone !== 1 || st !== 2'b00 || sv !== 1'b1 || bp !== 4'd5) begin
      errors++;
      $display("FAIL legal_done: got cyc=%0d n=%0d st=%b sv=%b bp=%0d, want 13 1 00 1 5",
               done_cyc, ndone, st, sv, bp);
    end
    checks++;
    if (busy1 !== 1'b1 || busy_done !== 1'b1 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL legal_busy: got c1=%b done=%b after=%b, want 1 1 0", busy1, busy_done, busy_after);
    end
    checks++;
    if (mem[2] !== 8'h56 || mem[4] !== 8'h00 || mem[5] !== 8'h01) begin
      errors++;
      $display("FAIL legal_mem: got %h %h %h, want 56 00 01", mem[2], mem[4], mem[5]);
    end
    checks++;
    if (bus.status !== 2'b00 || bus.solved !== 1'b1) begin
      errors++;
      $display("FAIL legal_hold: got st=%b sv=%b, want 00 1", bus.status, bus.solved);
    end
  endtask

  task automatic test_illegal();
    load_rf(8'h12, 8'h34, 8'h50, 8'h78, 8'h60, 8'h00);
    run_cmd(2'b11, 0, 0, 12);
    checks++;
    if (done_cyc !== 7 || st !== 2'b01 || sv !== 1'b0 || bp !== 4'd5 || nwr !== 0 || mem[5] !== 8'h00) begin
      errors++;
      $display("FAIL illegal_right: got cyc=%0d st=%b sv=%b bp=%0d nwr=%0d depth=%h, want 7 01 0 5 0 00",
               done_cyc, st, sv, bp, nwr, mem[5]);
    end
    // Solved board, blank at pos 8 cannot move down; board still reports solved.
    load_rf(8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00);
    run_cmd(2'b01, 0, 0, 12);
    checks++;
    if (done_cyc !== 7 || st !== 2'b01 || sv !== 1'b1 || bp !== 4'd8 || nwr !== 0) begin
      errors++;
      $display("FAIL illegal_down: got cyc=%0d st=%b sv=%b bp=%0d nwr=%0d, want 7 01 1 8 0",
               done_cyc, st, sv, bp, nwr);
    end
  endtask

  task automatic test_bad_board();
    load_rf(8'h10, 8'h34, 8'h50, 8'h78, 8'h60, 8'h00);
    run_cmd(2'b01, 0, 0, 12);
    checks++;
    if (done_cyc !== 7 || st !== 2'b10 || sv !== 1'b0 || nwr !== 0) begin
      errors++;
      $display("FAIL bad_two_blanks: got cyc=%0d st=%b sv=%b nwr=%0d, want 7 10 0 0",
               done_cyc, st, sv, nwr);
    end
    // Zero low nibble of byte 4 is ignored, so this board has no blank.
    load_rf(8'h12, 8'h34, 8'h56, 8'h78, 8'h90, 8'h00);
    run_cmd(2'b00, 0, 0, 12);
    checks++;
    if (done_cyc !== 7 || st !== 2'b10 || sv !== 1'b0 || nwr !== 0) begin
      errors++;
      $display("FAIL bad_no_blank: got cyc=%0d st=%b sv=%b nwr=%0d, want 7 10 0 0",
               done_cyc, st, sv, nwr);
    end
  endtask

  task automatic test_depth_sat();
    load_rf(8'h12, 8'h34, 8'h50, 8'h78, 8'h60, 8'hFE);
    run_cmd(2'b01, 0, 0, 16);
    checks++;
    if (st !== 2'b00 || sv !== 1'b1 || wd[5] !== 8'hFF || mem[5] !== 8'hFF) begin
      errors++;
      $display("FAIL sat_first: got st=%b sv=%b wdata=%h depth=%h, want 00 1 FF FF", st, sv, wd[5], mem[5]);
    end
    run_cmd(2'b00, 0, 0, 16);
    checks++;
    if (st !== 2'b00 || sv !== 1'b0 || bp !== 4'd8 || wd[5] !== 8'hFF || mem[5] !== 8'hFF) begin
      errors++;
      $display("FAIL sat_second: got st=%b sv=%b bp=%0d wdata=%h depth=%h, want 00 0 8 FF FF",
               st, sv, bp, wd[5], mem[5]);
    end
    checks++;
    if (wd[2] !== 8'h50 || wd[4] !== 8'h60 || mem[2] !== 8'h50) begin
      errors++;
      $display("FAIL sat_board: got w2=%h w4=%h m2=%h, want 50 60 50", wd[2], wd[4], mem[2]);
    end
  endtask

  task automatic test_back_to_back();
    load_rf(8'h12, 8'h34, 8'h50, 8'h78, 8'h60, 8'h00);
    run_cmd(2'b01, 3, 9, 24);
    checks++;
    if (ndone !== 1 || done_cyc !== 13 || nwr !== 6 || mem[5] !== 8'h01) begin
      errors++;
      $display("FAIL b2b_ignore: got ndone=%0d cyc=%0d nwr=%0d depth=%h, want 1 13 6 01",
               ndone, done_cyc, nwr, mem[5]);
    end
  endtask

  task automatic test_reset_mid();
    int act;
    logic we8, we9;
    load_rf(8'h01, 8'h23, 8'h45, 8'h67, 8'h80, 8'h07);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dir   = 2'b01;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);          // now in cycle 8
    we8 = bus.rf_we;
    rst_n = 1'b0;
    @(negedge clk);                      // cycle 9
    we9 = bus.rf_we;
    checks++;
    if (we8 !== 1'b1 || we9 !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort: got we8=%b we9=%b busy=%b, want 1 0 0", we8, we9, bus.busy);
    end
    rst_n = 1'b1;
    act = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.rf_we || bus.busy || bus.done) act++;
    end
    checks++;
    if (act !== 0) begin
      errors++; $display("FAIL rstmid_idle: got %0d active cycles, want 0", act);
    end
    checks++;
    if (mem[0] !== 8'h31 || mem[2] !== 8'h45 || mem[4] !== 8'h80 || mem[5] !== 8'h07) begin
      errors++;
      $display("FAIL rstmid_mem: got %h %h %h %h, want 31 45 80 07", mem[0], mem[2], mem[4], mem[5]);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.dir   = 2'b00;
    test_reset();
    test_legal();
    test_illegal();
    test_bad_board();
    test_depth_sat();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/puzzle_move_engine.md
Name: puzzle_move_engine

Overview:
Bus master for the 8-puzzle register file. Applies one blank-tile move per command:
- reads the packed 3x3 board byte-serially over the file's read port;
- locates the blank, checks legality and swaps the blank with its neighbour;
- writes the board back byte-serially and increments the depth byte;
- reports legal/illegal/bad-board status and whether the IDEAL arrangement is reached.

It sits between the search controller (start/dir handshake) and the register file (single combinational read port, single synchronous write port).

Parameters:
BOARD_BASE, 5'd0, first of 5 consecutive byte addresses holding the board
DEPTH_ADDR, 5'd5, address of 8-bit move-depth counter byte
IDEAL, 36'h123456780, solved arrangement (position 0 in bits [35:32])

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
start  in  1  command request; sampled only in IDLE
dir  in  2  blank move: 00 up (p-3), 01 down (p+3), 10 left (p-1), 11 right (p+1)
busy  out  1  high from the cycle after start acceptance until DONE inclusive
done  out  1  one-cycle pulse, command complete
status  out  2  00 ok, 01 illegal move, 10 bad board; valid while done=1, held until next done
solved  out  1  board (after the move, or unchanged board) equals IDEAL; updated with done
blank_pos  out  4  blank position 0..8 found by the last command; updated with done
rf_raddr  out  5  register-file read address
rf_rdata  in  8  register-file read data, combinational from rf_raddr
rf_waddr  out  5  register-file write address
rf_wdata  out  8  register-file write data
rf_we  out  1  register-file write enable

Behaviour:
Board packing:
- Position p = 3*row + col, row-major, p=0 top-left.
- Byte BOARD_BASE+k (k=0..3): high nibble = pos 2k, low nibble = pos 2k+1.
- Byte BOARD_BASE+4: high nibble = pos 8; low nibble ignored on read, written 0.

Reset:
- state=IDLE.
- busy=0, done=0, status=00, solved=0, blank_pos=0.
- rf_we=0, rf_raddr=rf_waddr=0, rf_wdata=0, internal board/dir registers cleared.
- Reset mid-command aborts at the next edge. No further writes occur; bytes already written stay written.

FSM, cycle numbering from the edge E0 that samples start=1 in IDLE:
- IDLE: rf_we=0. On start, latch dir and go to READ.
- READ, cycles 1-5: rf_raddr=BOARD_BASE+i for i=0..4; byte captured at the end of each cycle.
- FIND, cycle 6:
  - count zero nibbles; if count != 1, status=10;
  - else check legality: up needs row>0, down row<2, left col>0, right col<2; illegal gives status=01;
  - else swap the nibbles at p and the target position into the board register, status=00.
  - Legal moves go to WRITE; status 01/10 go to DONE.
- WRITE, cycles 7-11: rf_we=1, rf_waddr=BOARD_BASE+i, rf_wdata=new byte i.
- DEPTH, cycle 12:
  - rf_raddr=rf_waddr=DEPTH_ADDR, rf_we=1;
  - rf_wdata = rf_rdata+1, saturating at 8'hFF (FF stays FF).
- DONE:
  - done=1 for one cycle; status, blank_pos (pre-move blank position) and solved are registered.
  - Legal command: done in cycle 13. Illegal or bad board: done in cycle 7.
  - Return to IDLE.

Rules:
- rf_we=0 in every state except WRITE and DEPTH.
- Illegal or bad-board commands perform zero writes, including depth.
- start while busy is ignored and is not queued. start held high re-triggers only from IDLE, i.e. the cycle after DONE.
- solved compares the full 36-bit board after the move, or the unchanged board on error. For bad board, solved=0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> all outputs 0, rf_we=0; no write for 20 cycles with start=0.
- Legal solving move: file bytes 12,34,50,78,60, depth=00; start, dir=01 -> writes 12,34,56,78,00 in cycles 7-11, depth=01 in cycle 12; done in cycle 13 with status=00, solved=1, blank_pos=5.
- Illegal move: same board, dir=11 (blank in col 2) -> done in cycle 7, status=01, solved=0, no rf_we pulse, depth stays 00.
- Bad board: bytes 10,34,50,78,60 (two blanks) -> done in cycle 7, status=10, no writes; all-nonzero board also gives status=10.
- Depth saturation: depth=FE, two legal moves -> depth FF then FF; both report status=00.
- Protocol: pulse start again in cycles 3 and 9 -> ignored, exactly one done. Assert rst_n=0 in cycle 8 -> no rf_we from the next edge; after release, idle until a new start.
